// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory address, captures the
// returned word on each memory ack into a small prefetch FIFO of {pc, inst},
// and presents the FIFO head to decode through a valid/ready handshake.
// A redirect from EX flushes the FIFO and restarts fetch at the aligned target.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    input  logic        im_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [2:0]  fifo_count
);

    // Depth is 2 or 4, so the pointers wrap naturally at their width.
    localparam int          PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  DEPTH_C = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_e;

    // Architectural state
    logic [31:0]      pc_q,       pc_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [2:0]       count_q,    count_d;
    fifo_state_e      state_q,    state_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      id_inst_q,  id_inst_d;
    logic [31:0]      id_pc_q,    id_pc_d;

    // Prefetch storage
    logic [31:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0] fifo_inst_q [FIFO_DEPTH];

    // Handshake decode
    logic       pop_s;
    logic       push_s;
    logic       full_s;
    logic [2:0] rem_s;
    logic       push_to_head_s;

    // The low two target bits are dropped by the alignment; keep them visible
    // so the discard is deliberate.
    logic unused_s;
    assign unused_s = ^redirect_pc[1:0];

    // Pop/push qualification: a redirect discards the ack, and a full FIFO
    // only takes a new word when the head leaves in the same cycle.
    always_comb begin
        pop_s  = id_valid_q & id_ready;
        full_s = (state_q == ST_FULL);
        push_s = im_ack & ~redirect_valid & (~full_s | pop_s);
        rem_s  = count_q - {2'b00, pop_s};
        // The new word becomes the head when nothing older survives this edge.
        push_to_head_s = push_s & (rem_s == 3'd0);
    end

    // Next-state for PC, pointers, count, occupancy FSM and head registers.
    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 3'd0;
            state_d  = ST_EMPTY;
        end else begin
            if (push_s) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase

            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d = ST_PARTIAL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_PARTIAL: begin
                    if (push_s && !pop_s) begin
                        state_d = (count_q == (DEPTH_C - 3'd1)) ? ST_FULL : ST_PARTIAL;
                    end else if (pop_s && !push_s) begin
                        state_d = (count_q == 3'd1) ? ST_EMPTY : ST_PARTIAL;
                    end else begin
                        state_d = ST_PARTIAL;
                    end
                end
                ST_FULL: begin
                    if (pop_s && !push_s) begin
                        state_d = ST_PARTIAL;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Head registers follow the post-edge head; with an empty FIFO they
        // keep their last value.
        id_valid_d = (count_d != 3'd0);
        if (redirect_valid || (count_d == 3'd0)) begin
            id_inst_d = id_inst_q;
            id_pc_d   = id_pc_q;
        end else if (push_to_head_s) begin
            id_inst_d = im_inst;
            id_pc_d   = pc_q;
        end else begin
            id_inst_d = fifo_inst_q[rd_ptr_d];
            id_pc_d   = fifo_pc_q[rd_ptr_d];
        end
    end

    // Control state, occupancy FSM and registered head outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= 3'd0;
            state_q    <= ST_EMPTY;
            id_valid_q <= 1'b0;
            id_inst_q  <= 32'h0000_0000;
            id_pc_q    <= 32'h0000_0000;
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // Prefetch storage: zeroed on reset, written at the tail on each push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= 32'h0000_0000;
                fifo_inst_q[i] <= 32'h0000_0000;
            end
        end else begin
            if (push_s) begin
                fifo_pc_q[wr_ptr_q]   <= pc_q;
                fifo_inst_q[wr_ptr_q] <= im_inst;
            end else begin
                fifo_pc_q[wr_ptr_q]   <= fifo_pc_q[wr_ptr_q];
                fifo_inst_q[wr_ptr_q] <= fifo_inst_q[wr_ptr_q];
            end
        end
    end

    assign im_addr    = pc_q;
    assign id_valid   = id_valid_q;
    assign id_inst    = id_inst_q;
    assign id_pc      = id_pc_q;
    assign fifo_count = count_q;

endmodule
